// File: rtl/mont_mul_param_pkg.sv
// Shared types for the Montgomery multiplier: controller states and the accumulator width.
package mont_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Two guard bits keep acc + b + n (< 4n) exact.
  function automatic int acc_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/mont_mul_param_if.sv
// Operation request/response bundle between the exponentiation controller and the multiplier.
interface mont_mul_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] z;

  modport master (
    output start, a, b, n,
    input  busy, done, err, z
  );

  modport slave (
    input  start, a, b, n,
    output busy, done, err, z
  );
endinterface

// File: rtl/mont_mul_param_step.sv
// One radix-2 Montgomery iteration: conditionally add b, make even by adding n, halve.
module mont_step
  import mont_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int AW    = acc_width(WIDTH)
) (
  input  logic [AW-1:0]    acc,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [AW-1:0]    acc_next
);

  logic [AW-1:0] t1_s;
  logic [AW-1:0] t2_s;

  // Full-width sums; the halving drops only the forced-zero LSB.
  always_comb begin
    t1_s = acc;
    if (bit_in) begin
      t1_s = acc + {2'b00, b};
    end else begin
      t1_s = acc;
    end
    t2_s = t1_s;
    if (t1_s[0]) begin
      t2_s = t1_s + {2'b00, n};
    end else begin
      t2_s = t1_s;
    end
    acc_next = t2_s >> 1;
  end

endmodule

// File: rtl/mont_mul_param.sv
// Radix-2 Montgomery multiplier: z = a*b*2^-WIDTH mod n, one iteration per clock,
// start/busy/done handshake and even-modulus flag.
module mont_mul_param
  import mont_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic             clk,
  input logic             rstn,
  mont_mul_param_if.slave bus
);

  localparam int AW = acc_width(WIDTH);

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] n_r;
  logic [AW-1:0]    acc_r;
  logic [CNT_W-1:0] i_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [WIDTH-1:0] z_r;

  logic [AW-1:0]    acc_next_s;
  logic [WIDTH-1:0] z_fin_s;
  logic             last_s;

  // a is consumed LSB-first by shifting, so the current bit is always a_sh_r[0].
  mont_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc_r),
    .bit_in   (a_sh_r[0]),
    .b        (b_r),
    .n        (n_r),
    .acc_next (acc_next_s)
  );

  assign last_s = (i_r == CNT_W'(WIDTH - 1));

  // Final reduction; when acc >= n the true difference is < n, so low bits suffice.
  always_comb begin
    if (acc_r >= {2'b00, n_r}) begin
      z_fin_s = acc_r[WIDTH-1:0] - n_r;
    end else begin
      z_fin_s = acc_r[WIDTH-1:0];
    end
  end

  // Controller: accept, iterate WIDTH times, reduce and report.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      n_r     <= {WIDTH{1'b0}};
      acc_r   <= {AW{1'b0}};
      i_r     <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      z_r     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r  <= bus.a;
            b_r     <= bus.b;
            n_r     <= bus.n;
            acc_r   <= {AW{1'b0}};
            i_r     <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r  <= acc_next_s;
          a_sh_r <= a_sh_r >> 1;
          i_r    <= i_r + CNT_W'(1);
          if (last_s) begin
            state_r <= ST_FIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FIN: begin
          z_r     <= z_fin_s;
          err_r   <= ~n_r[0];
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;
  assign bus.z    = z_r;

endmodule

// File: tb/tb_mont_mul_param.sv
// Bench for mont_mul_param at WIDTH 8, 32 and 64 against an arithmetic reference model.
module tb_mont_mul_param;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mont_mul_param_if #(.WIDTH(8))  if8  ();
  mont_mul_param_if #(.WIDTH(32)) if32 ();
  mont_mul_param_if #(.WIDTH(64)) if64 ();

  mont_mul_param #(.WIDTH(8))  u8  (.clk(clk), .rstn(rstn), .bus(if8.slave));
  mont_mul_param #(.WIDTH(32)) u32 (.clk(clk), .rstn(rstn), .bus(if32.slave));
  mont_mul_param #(.WIDTH(64)) u64 (.clk(clk), .rstn(rstn), .bus(if64.slave));

  int total = 0;
  int bad   = 0;

  logic [2:0]  st_w, busy_w, done_w, err_w;
  logic [63:0] a_w [3];
  logic [63:0] b_w [3];
  logic [63:0] n_w [3];
  logic [63:0] z_w [3];

  assign st_w   = {if64.start, if32.start, if8.start};
  assign busy_w = {if64.busy, if32.busy, if8.busy};
  assign done_w = {if64.done, if32.done, if8.done};
  assign err_w  = {if64.err, if32.err, if8.err};
  assign a_w[0] = 64'(if8.a);
  assign a_w[1] = 64'(if32.a);
  assign a_w[2] = if64.a;
  assign b_w[0] = 64'(if8.b);
  assign b_w[1] = 64'(if32.b);
  assign b_w[2] = if64.b;
  assign n_w[0] = 64'(if8.n);
  assign n_w[1] = 64'(if32.n);
  assign n_w[2] = if64.n;
  assign z_w[0] = 64'(if8.z);
  assign z_w[1] = 64'(if32.z);
  assign z_w[2] = if64.z;

  function automatic int wd(input int k);
    case (k)
      0:       return 8;
      1:       return 32;
      default: return 64;
    endcase
  endfunction

  // a*b*2^-w mod n: reduce the full product, then divide by 2 w times in Z/nZ.
  function automatic logic [63:0] mont_ref(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] n, input int w);
    logic [127:0] x;
    logic [127:0] nn;
    nn = {64'd0, n};
    x  = ({64'd0, a} * {64'd0, b}) % nn;
    for (int k = 0; k < w; k++) begin
      if (x[0]) x = (x + nn) >> 1;
      else      x = x >> 1;
    end
    return x[63:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ops(input int k, input logic [63:0] a, input logic [63:0] b, input logic [63:0] n);
    case (k)
      0:       begin if8.a  = a[7:0];  if8.b  = b[7:0];  if8.n  = n[7:0];  end
      1:       begin if32.a = a[31:0]; if32.b = b[31:0]; if32.n = n[31:0]; end
      default: begin if64.a = a;       if64.b = b;       if64.n = n;       end
    endcase
  endtask

  task automatic set_start(input int k, input logic s);
    case (k)
      0:       if8.start  = s;
      1:       if32.start = s;
      default: if64.start = s;
    endcase
  endtask

  // Model: operation timing and results as the handshake defines them.
  int          m_cnt  [3];
  logic        m_busy [3];
  logic        m_done [3];
  logic        m_err  [3];
  logic        m_perr [3];
  logic        m_zok  [3];
  logic [63:0] m_z    [3];
  logic [63:0] m_pz   [3];

  always @(posedge clk or negedge rstn) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstn) begin
        m_cnt[k] <= 0; m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_err[k] <= 1'b0;
        m_perr[k] <= 1'b0; m_zok[k] <= 1'b1; m_z[k] <= 64'd0; m_pz[k] <= 64'd0;
      end else if (m_cnt[k] == 0) begin
        m_done[k] <= 1'b0;
        if (st_w[k]) begin
          m_cnt[k]  <= wd(k) + 1;
          m_busy[k] <= 1'b1;
          m_err[k]  <= 1'b0;
          m_perr[k] <= ~n_w[k][0];
          m_pz[k]   <= n_w[k][0] ? mont_ref(a_w[k], b_w[k], n_w[k], wd(k)) : 64'd0;
        end
      end else begin
        m_cnt[k] <= m_cnt[k] - 1;
        if (m_cnt[k] == 1) begin
          m_done[k] <= 1'b1;
          m_busy[k] <= 1'b0;
          m_err[k]  <= m_perr[k];
          m_z[k]    <= m_pz[k];
          m_zok[k]  <= ~m_perr[k];
        end else begin
          m_done[k] <= 1'b0;
        end
      end
    end
  end

  // Compare every output of every instance on every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy[w%0d]", wd(k)), {63'd0, busy_w[k]}, {63'd0, m_busy[k]});
      chk($sformatf("done[w%0d]", wd(k)), {63'd0, done_w[k]}, {63'd0, m_done[k]});
      chk($sformatf("err[w%0d]", wd(k)),  {63'd0, err_w[k]},  {63'd0, m_err[k]});
      if (m_zok[k]) chk($sformatf("z[w%0d]", wd(k)), z_w[k], m_z[k]);
    end
  end

  // lat counts clock edges from the accept edge (counted as 1) to the edge raising done.
  task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b, input logic [63:0] n,
                        output logic [63:0] z, output logic e, output int lat);
    @(negedge clk);
    set_ops(k, a, b, n);
    set_start(k, 1'b1);
    @(negedge clk);
    set_start(k, 1'b0);
    set_ops(k, ~a, ~b, ~n);
    lat = 1;
    while (!done_w[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!done_w[k]) chk("op_timeout", 64'd0, 64'd1);
    z = z_w[k];
    e = err_w[k];
  endtask

  logic [63:0] zz, aa, bb, nn, mask;
  logic        ee;
  int          lat, nd, nb, first, second;

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_start(k, 1'b0);
      set_ops(k, 64'd0, 64'd0, 64'd0);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", {63'd0, busy_w[k]}, 64'd0);
      chk("rst_done", {63'd0, done_w[k]}, 64'd0);
      chk("rst_err",  {63'd0, err_w[k]},  64'd0);
      chk("rst_z",    z_w[k],             64'd0);
    end
    rstn = 1'b1;

    run_op(0, 64'd5, 64'd7, 64'd13, zz, ee, lat);
    chk("w8_5x7_z", zz, 64'd1);
    chk("w8_5x7_err", {63'd0, ee}, 64'd0);
    chk("w8_latency", 64'(lat), 64'd10);
    run_op(0, 64'd12, 64'd12, 64'd13, zz, ee, lat);
    chk("w8_12x12_z", zz, 64'd3);
    run_op(0, 64'd0, 64'd9, 64'd13, zz, ee, lat);
    chk("w8_0x9_z", zz, 64'd0);

    run_op(1, 64'd5, 64'h1234_5678, 64'hFFFF_FFFB, zz, ee, lat);
    chk("w32_rmodn_z", zz, 64'h1234_5678);
    chk("w32_latency", 64'(lat), 64'd34);
    run_op(1, 64'hFFFF_FFFE, 64'hFFFF_FFFE, 64'hFFFF_FFFF, zz, ee, lat);
    chk("w32_maxmod_z", zz, 64'd1);
    run_op(2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, zz, ee, lat);
    chk("w64_maxmod_z", zz, 64'd1);
    chk("w64_latency", 64'(lat), 64'd66);

    run_op(0, 64'd5, 64'd7, 64'd12, zz, ee, lat);
    chk("even_err", {63'd0, ee}, 64'd1);
    chk("even_latency", 64'(lat), 64'd10);
    run_op(0, 64'd5, 64'd7, 64'd13, zz, ee, lat);
    chk("err_cleared", {63'd0, ee}, 64'd0);
    chk("after_even_z", zz, 64'd1);

    // start held for 20 edges: second op accepted on the edge ending the done cycle
    @(negedge clk);
    set_ops(0, 64'd12, 64'd12, 64'd13);
    set_start(0, 1'b1);
    nd = 0; first = -1; second = -1;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (c == 20) set_start(0, 1'b0);
      if (done_w[0]) begin
        nd++;
        if (first < 0) first = c;
        else second = c;
      end
    end
    chk("held_start_ops", 64'(nd), 64'd2);
    chk("held_first_done", 64'(first), 64'd10);
    chk("held_second_done", 64'(second), 64'd20);

    // start pulse mid-RUN is ignored; busy spans RUN and FIN only
    @(negedge clk);
    set_ops(0, 64'd12, 64'd12, 64'd13);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    nb = 0; nd = 0; zz = 64'hDEAD;
    for (int c = 1; c <= 14; c++) begin
      if (busy_w[0]) nb++;
      if (done_w[0]) begin nd++; zz = z_w[0]; end
      if (c == 4) begin set_ops(0, 64'd1, 64'd1, 64'd13); set_start(0, 1'b1); end
      if (c == 5) set_start(0, 1'b0);
      @(negedge clk);
    end
    chk("midrun_busy_cycles", 64'(nb), 64'd9);
    chk("midrun_done_count", 64'(nd), 64'd1);
    chk("midrun_z", zz, 64'd3);

    // reset during RUN aborts with no done
    @(negedge clk);
    set_ops(0, 64'd5, 64'd7, 64'd13);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy_w[0]}, 64'd0);
    chk("abort_done", {63'd0, done_w[0]}, 64'd0);
    chk("abort_z", z_w[0], 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_w[0]) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    run_op(0, 64'd5, 64'd7, 64'd13, zz, ee, lat);
    chk("post_abort_z", zz, 64'd1);

    for (int k = 0; k < 3; k++) begin
      mask = (wd(k) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << wd(k)) - 64'd1);
      for (int r = 0; r < 300; r++) begin
        nn = ({$urandom, $urandom} & mask) | 64'd1;
        if (r == 0) nn = mask;
        if (nn == 64'd1) nn = 64'd3;
        aa = {$urandom, $urandom} % nn;
        bb = {$urandom, $urandom} % nn;
        run_op(k, aa, bb, nn, zz, ee, lat);
        chk($sformatf("rand_z[w%0d]", wd(k)), zz, mont_ref(aa, bb, nn, wd(k)));
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
